// File: rtl/sdram_cache_port.sv
// sdram_cache_port
// Sits between the two-way cache's sdram_* port and the SDRAM core's
// word-stream command interface. A line read is issued to the core as one
// 4-word burst. The returned words, which may arrive with arbitrary gaps,
// are gathered into a small buffer and then replayed to the cache on four
// back-to-back cycles. A write is issued to the core as a single word.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for a cache request
// RD_CMD     | burst read command held on the core until mem_ack
// RD_COLLECT | command taken; gathering the remaining read words
// RD_PLAY    | replaying buf[0..3] to the cache, fill pulse on word 0
// WR_CMD     | write command held on the core until mem_ack
// WR_DONE    | write taken; waiting for the cache to drop sdram_req

module sdram_cache_port #(
    parameter int MEM_ADDR_BITS = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              sdram_addr,
    input  logic                     sdram_req,
    input  logic                     sdram_rw,
    input  logic [15:0]              data_to_sdram,
    output logic [15:0]              data_from_sdram,
    output logic                     sdram_fill,
    output logic                     sdram_wack,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic                     mem_req,
    output logic                     mem_rw,
    output logic                     mem_burst,
    output logic [15:0]              mem_wdata,
    input  logic                     mem_ack,
    input  logic [15:0]              mem_rdata,
    input  logic                     mem_rvalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_COLLECT,
        S_RD_PLAY,
        S_WR_CMD,
        S_WR_DONE
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_cnt;
    logic [15:0]              r_buf [4];
    logic [15:0]              r_data_from_sdram;
    logic                     r_sdram_fill;
    logic                     r_sdram_wack;
    logic [MEM_ADDR_BITS-1:0] r_mem_addr;
    logic                     r_mem_req;
    logic                     r_mem_rw;
    logic                     r_mem_burst;
    logic [15:0]              r_mem_wdata;

    logic                     w_last_word;
    logic                     w_unused_addr;

    // The fourth word of a burst is the one arriving while cnt already reads 3.
    assign w_last_word = mem_rvalid && (r_cnt == 2'd3);

    // Address bits above the core's range are dropped on purpose.
    assign w_unused_addr = &{1'b0, sdram_addr[31:MEM_ADDR_BITS]};

    assign data_from_sdram = r_data_from_sdram;
    assign sdram_fill      = r_sdram_fill;
    assign sdram_wack      = r_sdram_wack;
    assign mem_addr        = r_mem_addr;
    assign mem_req         = r_mem_req;
    assign mem_rw          = r_mem_rw;
    assign mem_burst       = r_mem_burst;
    assign mem_wdata       = r_mem_wdata;

    // Request sequencing, word collection and line playout, all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_cnt             <= 2'd0;
            for (int i = 0; i < 4; i++) r_buf[i] <= 16'h0000;
            r_data_from_sdram <= 16'h0000;
            r_sdram_fill      <= 1'b0;
            r_sdram_wack      <= 1'b0;
            r_mem_addr        <= '0;
            r_mem_req         <= 1'b0;
            r_mem_rw          <= 1'b0;
            r_mem_burst       <= 1'b0;
            r_mem_wdata       <= 16'h0000;
        end else begin
            r_sdram_fill <= 1'b0;
            r_sdram_wack <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (sdram_req) begin
                        r_mem_req <= 1'b1;
                        if (sdram_rw) begin
                            r_mem_addr  <= {sdram_addr[MEM_ADDR_BITS-1:3], 3'b000};
                            r_mem_rw    <= 1'b1;
                            r_mem_burst <= 1'b1;
                            r_cnt       <= 2'd0;
                            r_state     <= S_RD_CMD;
                        end else begin
                            r_mem_addr  <= sdram_addr[MEM_ADDR_BITS-1:0];
                            r_mem_wdata <= data_to_sdram;
                            r_mem_rw    <= 1'b0;
                            r_mem_burst <= 1'b0;
                            r_state     <= S_WR_CMD;
                        end
                    end
                end

                S_RD_CMD, S_RD_COLLECT: begin
                    // The core may return data in the same cycle it takes the command.
                    if (r_state == S_RD_CMD && mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_burst <= 1'b0;
                        r_state     <= S_RD_COLLECT;
                    end
                    if (mem_rvalid) begin
                        r_buf[r_cnt] <= mem_rdata;
                        r_cnt        <= r_cnt + 2'd1;
                    end
                    // Word 0 goes out with the fill pulse on the very next cycle.
                    if (w_last_word) begin
                        r_mem_req         <= 1'b0;
                        r_mem_burst       <= 1'b0;
                        r_sdram_fill      <= 1'b1;
                        r_data_from_sdram <= r_buf[0];
                        r_state           <= S_RD_PLAY;
                    end
                end

                S_RD_PLAY: begin
                    // cnt wrapped to 0 on entry; it indexes the word currently on the bus.
                    if (r_cnt == 2'd3) begin
                        r_cnt   <= 2'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_data_from_sdram <= r_buf[r_cnt + 2'd1];
                        r_cnt             <= r_cnt + 2'd1;
                    end
                end

                S_WR_CMD: begin
                    if (mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_sdram_wack <= 1'b1;
                        r_state      <= S_WR_DONE;
                    end
                end

                S_WR_DONE: begin
                    // A write the cache still holds must not be issued twice.
                    if (!sdram_req) r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sdram_cache_port.md
# sdram_cache_port

Responder for the cache's SDRAM-side burst protocol. It accepts line-fill reads and single-word writes from the two-way cache's `sdram_*` port, and issues them to the SDRAM core's word-stream command interface. Read data returns from the core with arbitrary gaps, so the block collects it into a 4-word buffer. It then replays the line to the cache on four consecutive cycles, which is the back-to-back fill the cache's fill sequence requires.

## Interface

**Parameters**
- `MEM_ADDR_BITS`, default 25: width of `mem_addr`; upper cache address bits are dropped.

**Ports**
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sdram_addr` in 32: cache request address; bits [2:0] are zero for reads.
- `sdram_req` in 1: cache request, held until served.
- `sdram_rw` in 1: 1 = line read, 0 = word write.
- `data_to_sdram` in 16: cache write data.
- `data_from_sdram` out 16: fill data to the cache.
- `sdram_fill` out 1: one-cycle pulse aligned with word 0 of the line.
- `sdram_wack` out 1: one-cycle pulse when a write is accepted by the core.
- `mem_addr` out MEM_ADDR_BITS: core address.
- `mem_req` out 1: core command request.
- `mem_rw` out 1: 1 = read, 0 = write.
- `mem_burst` out 1: 1 = 4-word burst read.
- `mem_wdata` out 16: core write data.
- `mem_ack` in 1: core accepts the command in any cycle where `mem_req && mem_ack`.
- `mem_rdata` in 16: core read data.
- `mem_rvalid` in 1: `mem_rdata` is valid this cycle.

## Operation

**States:** IDLE, RD_CMD, RD_COLLECT, RD_PLAY, WR_CMD, WR_DONE.

**IDLE**
- With `sdram_req=1`, `sdram_rw=1`, register the aligned address `{sdram_addr[MEM_ADDR_BITS-1:3],3'b000}`.
- Set `mem_req=1`, `mem_rw=1`, `mem_burst=1`, clear the word counter, and go to RD_CMD.
- With `sdram_req=1`, `sdram_rw=0`, register `sdram_addr[MEM_ADDR_BITS-1:0]` and `data_to_sdram`.
- Set `mem_req=1`, `mem_rw=0`, `mem_burst=0`, and go to WR_CMD.

**RD_CMD**
- Hold the command until `mem_ack`.
- On `mem_ack`, clear `mem_req` and `mem_burst` and go to RD_COLLECT.

**RD_COLLECT**
- On each `mem_rvalid`, store `mem_rdata` in `buf[cnt]` and increment `cnt` (2-bit).
- Go to RD_PLAY when the 4th word is stored (`cnt==3` with `rvalid`).

**Word collection rules**
- Words are collected in both RD_CMD and RD_COLLECT.
- This includes `mem_rvalid` arriving in the same cycle as `mem_ack`.
- If the 4th word arrives while still in RD_CMD, go directly to RD_PLAY.
- `mem_rvalid` in any other state is ignored.

**RD_PLAY**
- Drive `buf[0..3]` on `data_from_sdram` on four consecutive cycles, with `sdram_fill=1` on the first only.
- Then return to IDLE.

**WR_CMD**
- On `mem_ack`, clear `mem_req`, pulse `sdram_wack`, and go to WR_DONE.

**WR_DONE**
- Wait for `sdram_req=0`, then go to IDLE.
- This prevents re-issuing a held write.

**Address handling**
- No address arithmetic.
- Burst word order is 0..3 from the aligned base; there is no critical-word-first ordering.

## Timing

**Reset values:** `mem_req`, `mem_rw`, `mem_burst`, `sdram_fill`, `sdram_wack` = 0; `mem_addr`, `mem_wdata`, `data_from_sdram` = 0; state IDLE; `cnt` = 0.

**Read latency**
- Request sampled in IDLE at cycle 0 gives `mem_req=1` at cycle 1.
- If the last `mem_rvalid` is sampled at cycle n:
  - `sdram_fill=1` with word 0 at n+1.
  - Words 1, 2, 3 at n+2, n+3, n+4.
  - IDLE at n+5.
- `data_from_sdram` holds word 3 after playout.

**Write latency:** `mem_ack` sampled at cycle k gives `sdram_wack=1` and `mem_req=0` at k+1.

**Request handshake**
- A new request is accepted only in IDLE.
- The cache drops `sdram_req` the cycle after the fill pulse, so it is low before IDLE is re-entered and no duplicate read occurs.

**Boundary conditions**
- Gaps between `mem_rvalid` words have no effect on playout spacing.
- `mem_ack` may arrive any number of cycles late, including the cycle after `mem_req` rises.
- **Reset mid-operation:** state goes to IDLE and `mem_req` drops asynchronously. No fill or `wack` is produced and the partial buffer is discarded.

## Test plan

- **Read, contiguous data:** read at 0x0000_1238, `mem_ack` 2 cycles after `mem_req`, `rvalid` on 4 consecutive cycles with 0xA0..0xA3.
  - Expect `mem_addr=0x1238`, `mem_burst=1`.
  - Expect fill pulse with 0xA0, then 0xA1, 0xA2, 0xA3 on the next cycles.
- **Read, gapped data:** `rvalid` words spaced 0, 3, 1, 5 idle cycles apart → playout still 4 consecutive cycles, starting exactly 1 cycle after the last `rvalid`.
- **Ack and rvalid together:** `mem_ack` coincides with the first `rvalid` (0x11), then 3 more words → all 4 captured, buffer order 0x11 first.
- **Write held by cache:** write 0xBEEF to 0x0200_0010, `sdram_req` held 6 cycles.
  - Expect exactly one `mem_req` with `mem_wdata=0xBEEF` and `mem_addr=0x10` (25-bit).
  - Expect one `sdram_wack`; no second command until `sdram_req` falls.
- **Reset mid-burst:** assert `reset` after 2 of 4 read words → `mem_req=0` immediately, no `sdram_fill`. A following read returns only new-burst data.
